// File: rtl/counter_trend_monitor_pkg.sv
// counter_trend_pkg: trend FSM states, decoded step kinds and the step-to-state mapping.
package counter_trend_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {STABLE = 2'd0, UP = 2'd1, DOWN = 2'd2, FAULT = 2'd3} trend_state_e;
    typedef enum logic [1:0] {STEP_NONE = 2'd0, STEP_UP = 2'd1, STEP_DN = 2'd2, STEP_ERR = 2'd3} step_e;
    function automatic trend_state_e step_to_state(step_e s);
        return s == STEP_UP ? UP : s == STEP_DN ? DOWN : s == STEP_ERR ? FAULT : STABLE;
    endfunction
endpackage

// File: rtl/counter_trend_monitor_if.sv
// counter_trend_monitor_if: detector flags in, trend status out; max_run exists only with TREND_STATS_EN.
interface counter_trend_monitor_if #(parameter int RUN_W = 8, parameter int ERR_W = 8);
    import counter_trend_pkg::*;
    logic valid, incr, decr, error, clear;
    trend_state_e state;
    logic [RUN_W-1:0] run_len;
    logic up_trend, down_trend;
    logic [ERR_W-1:0] err_count;
    logic alarm;
`ifdef TREND_STATS_EN
    logic [RUN_W-1:0] max_run;
    modport master(output valid, incr, decr, error, clear,
                   input state, run_len, up_trend, down_trend, err_count, alarm, max_run);
    modport slave(input valid, incr, decr, error, clear,
                  output state, run_len, up_trend, down_trend, err_count, alarm, max_run);
`else
    modport master(output valid, incr, decr, error, clear,
                   input state, run_len, up_trend, down_trend, err_count, alarm);
    modport slave(input valid, incr, decr, error, clear,
                  output state, run_len, up_trend, down_trend, err_count, alarm);
`endif
endinterface

// File: rtl/counter_trend_monitor_sat_counter.sv
// sat_counter: saturating counter with sync zero and load-to-one; exposes its next value for look-ahead flags.
module sat_counter #(parameter int W = 8) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear_i,
    input  logic         load1_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] next_o
);
    logic [W-1:0] count_q, count_d;
    always_comb
        count_d = clear_i ? '0 : load1_i ? W'(1) : (inc_i && count_q != '1) ? count_q + W'(1) : count_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) count_q <= '0;
        else count_q <= count_d;
    assign count_o = count_q;
    assign next_o  = count_d;
endmodule

// File: rtl/counter_trend_monitor.sv
// counter_trend_monitor: trend FSM, run-length and error counters behind the counter detector.
// Optional TREND_STATS_EN adds max_run, the largest run_len ever registered.
module counter_trend_monitor
    import counter_trend_pkg::*;
#(
    parameter int RUN_W      = 8,
    parameter int RUN_THRESH = 4,
    parameter int ERR_W      = 8,
    parameter int ERR_LIMIT  = 3
) (
    input  logic clk,
    input  logic reset_n,
    counter_trend_monitor_if.slave bus
);
    trend_state_e state_q, state_d;
    step_e step;
    logic [RUN_W-1:0] run_q, run_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic up_q, up_d, dn_q, dn_d, alarm_q, alarm_d;
    logic same_dir, run_clr, run_ld, run_inc, err_inc;
    always_comb begin
        step     = (bus.error || (bus.incr && bus.decr)) ? STEP_ERR :
                   bus.incr ? STEP_UP : bus.decr ? STEP_DN : STEP_NONE;
        same_dir = (step == STEP_UP && state_q == UP) || (step == STEP_DN && state_q == DOWN);
        run_clr  = bus.clear || (bus.valid && (step == STEP_NONE || step == STEP_ERR));
        run_ld   = bus.valid && !same_dir && (step == STEP_UP || step == STEP_DN);
        run_inc  = bus.valid && same_dir;
        err_inc  = bus.valid && step == STEP_ERR;
    end
    sat_counter #(.W(RUN_W)) u_run (
        .clk(clk), .reset_n(reset_n), .clear_i(run_clr), .load1_i(run_ld), .inc_i(run_inc),
        .count_o(run_q), .next_o(run_d)
    );
    sat_counter #(.W(ERR_W)) u_err (
        .clk(clk), .reset_n(reset_n), .clear_i(bus.clear), .load1_i(1'b0), .inc_i(err_inc),
        .count_o(err_q), .next_o(err_d)
    );
    // Flags are derived from next-state values so they line up with state/run_len on the same edge.
    always_comb begin
        state_d = bus.clear ? STABLE : bus.valid ? step_to_state(step) : state_q;
        up_d    = state_d == UP && run_d >= RUN_W'(RUN_THRESH);
        dn_d    = state_d == DOWN && run_d >= RUN_W'(RUN_THRESH);
        alarm_d = !bus.clear && (alarm_q || err_d >= ERR_W'(ERR_LIMIT));
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= STABLE;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            alarm_q <= alarm_d;
        end
    assign bus.state      = state_q;
    assign bus.run_len    = run_q;
    assign bus.up_trend   = up_q;
    assign bus.down_trend = dn_q;
    assign bus.err_count  = err_q;
    assign bus.alarm      = alarm_q;
`ifdef TREND_STATS_EN
    logic [RUN_W-1:0] max_q, max_d;
    always_comb max_d = bus.clear ? '0 : run_d > max_q ? run_d : max_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) max_q <= '0;
        else max_q <= max_d;
    assign bus.max_run = max_q;
`endif
endmodule

// File: tb/tb_counter_trend_monitor.sv
// tb_counter_trend_monitor: directed steps with a spec-level model feeding an expectation queue.
// Two DUTs share stimulus: default widths, and RUN_W=3 for run-length saturation.
module tb_counter_trend_monitor;
    typedef struct {int st; int run; int up; int dn; int err; int al; int run3; int up3; int mx;} exp_t;
    logic clk = 1'b0;
    logic reset_n;
    int n_checks = 0;
    int n_errors = 0;
    exp_t q[$];
    int m_st, m_run, m_run3, m_err, m_al, m_mx;
    always #5 clk = ~clk;
    counter_trend_monitor_if #(.RUN_W(8), .ERR_W(8)) bus ();
    counter_trend_monitor_if #(.RUN_W(3), .ERR_W(8)) bus3 ();
    counter_trend_monitor #(.RUN_W(8), .RUN_THRESH(4), .ERR_W(8), .ERR_LIMIT(3)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave));
    counter_trend_monitor #(.RUN_W(3), .RUN_THRESH(4), .ERR_W(8), .ERR_LIMIT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3.slave));

    task automatic cmp(string tag, logic [31:0] got, int exp);
        n_checks++;
        assert (got === 32'(exp)) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmp_all(exp_t e);
        cmp("state", 32'(bus.state), e.st);
        cmp("run_len", 32'(bus.run_len), e.run);
        cmp("up_trend", 32'(bus.up_trend), e.up);
        cmp("down_trend", 32'(bus.down_trend), e.dn);
        cmp("err_count", 32'(bus.err_count), e.err);
        cmp("alarm", 32'(bus.alarm), e.al);
        cmp("run_len_w3", 32'(bus3.run_len), e.run3);
        cmp("up_trend_w3", 32'(bus3.up_trend), e.up3);
`ifdef TREND_STATS_EN
        cmp("max_run", 32'(bus.max_run), e.mx);
`endif
    endtask

    task automatic model_reset();
        m_st = 0; m_run = 0; m_run3 = 0; m_err = 0; m_al = 0; m_mx = 0;
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.st = m_st; e.run = m_run; e.err = m_err; e.al = m_al; e.run3 = m_run3; e.mx = m_mx;
        e.up  = int'(m_st == 1 && m_run >= 4);
        e.dn  = int'(m_st == 2 && m_run >= 4);
        e.up3 = int'(m_st == 1 && m_run3 >= 4);
        return e;
    endfunction

    task automatic model_step(bit v, bit i, bit d, bit e, bit c);
        int s;
        if (c) begin
            model_reset();
            return;
        end
        if (!v) return;
        s = (e || (i && d)) ? 3 : i ? 1 : d ? 2 : 0;
        if (s == 1 || s == 2) begin
            m_run  = (m_st == s) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
            m_run3 = (m_st == s) ? ((m_run3 < 7) ? m_run3 + 1 : 7) : 1;
        end else begin
            m_run = 0;
            m_run3 = 0;
        end
        if (s == 3 && m_err < 255) m_err++;
        if (m_err >= 3) m_al = 1;
        if (m_run > m_mx) m_mx = m_run;
        m_st = s;
    endtask

    task automatic drive(bit v, bit i, bit d, bit e, bit c);
        bus.valid = v;  bus.incr = i;  bus.decr = d;  bus.error = e;  bus.clear = c;
        bus3.valid = v; bus3.incr = i; bus3.decr = d; bus3.error = e; bus3.clear = c;
    endtask

    task automatic step(bit v, bit i, bit d, bit e, bit c);
        drive(v, i, d, e, c);
        model_step(v, i, d, e, c);
        q.push_back(snap());
        @(posedge clk);
        #1;
        cmp_all(q.pop_front());
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #12;
        q.push_back(snap());
        cmp_all(q.pop_front());
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) step(1, 1, 0, 0, 0);
        cmp("up_after_5_incr", 32'(bus.up_trend), 1);
        step(0, 0, 0, 0, 1);
        repeat (3) step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        cmp("run_after_turn", 32'(bus.run_len), 1);
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        cmp("alarm_at_limit", 32'(bus.alarm), 1);
        repeat (10) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        step(1, 1, 1, 0, 0);
        cmp("fault_state", 32'(bus.state), 3);
        repeat (5) step(0, 1, 0, 1, 0);
        repeat (9) step(1, 1, 0, 0, 0);
        cmp("run_w3_saturated", 32'(bus3.run_len), 7);
        step(1, 0, 1, 0, 0);
        repeat (4) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        repeat (5) step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        drive(1, 1, 0, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        q.push_back(snap());
        cmp_all(q.pop_front());
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        cmp("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
